// File: rtl/psum_accumulator.sv
// Accumulates adder-tree lane sums over a programmed number of passes and
// hands the result to write-back. Optional saturating add: `define PSUM_SAT_EN.
module psum_accumulator #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned PW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] num_passes,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data [0:LANES-1],
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data [0:LANES-1],
  output logic          busy,
  output logic          done
`ifdef PSUM_SAT_EN
  ,
  output logic          sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] acc [0:LANES-1];
  logic [DW-1:0] sum [0:LANES-1];
  logic [PW-1:0] pass_cnt;
  logic [PW-1:0] target;
  logic          beat;
  logic          last_beat;
`ifdef PSUM_SAT_EN
  logic [LANES-1:0] lane_sat;
`endif

  // Handshake and status decode straight from the state register
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
    beat      = in_ready && in_valid;
    last_beat = beat && (pass_cnt == target - PW'(1));
    for (int i = 0; i < LANES; i++) begin
      out_data[i] = acc[i];
    end
  end

  // Per-lane adder; in saturating builds, clamp on same-sign overflow
  always_comb begin
    logic [DW-1:0] raw;
    raw = '0;
`ifdef PSUM_SAT_EN
    lane_sat = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      raw    = acc[i] + in_data[i];
      sum[i] = raw;
`ifdef PSUM_SAT_EN
      if ((acc[i][DW-1] == in_data[i][DW-1]) && (raw[DW-1] != acc[i][DW-1])) begin
        lane_sat[i] = 1'b1;
        sum[i]      = acc[i][DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pass_cnt <= '0;
      target   <= '0;
      done     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
`ifdef PSUM_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target   <= (num_passes == '0) ? PW'(1) : num_passes;
            pass_cnt <= '0;
            state    <= ACCUM;
`ifdef PSUM_SAT_EN
            sat_flag <= 1'b0;
`endif
          end
        end
        ACCUM: begin
          if (beat) begin
            pass_cnt <= pass_cnt + PW'(1);
            // First beat loads directly, so no clear cycle between jobs
            for (int i = 0; i < LANES; i++) begin
              acc[i] <= (pass_cnt == '0) ? in_data[i] : sum[i];
            end
`ifdef PSUM_SAT_EN
            if ((pass_cnt != '0) && (|lane_sat)) begin
              sat_flag <= 1'b1;
            end
`endif
            if (last_beat) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream of the 64-to-8 adder tree. Consumes its 8 lane sums per pass and accumulates them across a programmed number of passes (K-tiles).
- Presents the final 8 partial sums to the write-back stage over a valid/ready handshake.
- Arithmetic is two's-complement signed, LANES x DW wide.

Parameters:
- LANES, 8, number of parallel lanes (matches adder tree output count)
- DW, 32, lane data width in bits
- PW, 8, width of the pass-count input

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a job; honoured only in IDLE
- num_passes  input  PW  passes to accumulate; sampled on start; 0 is treated as 1
- in_valid  input  1  adder tree result valid
- in_data  input  LANES x DW (unpacked [0:LANES-1])  adder tree lane sums
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  accumulated result available
- out_ready  input  1  consumer accepts result
- out_data  output  LANES x DW (unpacked [0:LANES-1])  accumulated sums
- busy  output  1  high in ACCUM or HOLD
- done  output  1  one-cycle pulse on the cycle the result handshake completes

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; acc[*]=0; pass_cnt=0.
  - in_ready=0, out_valid=0, busy=0, done=0, out_data=0.
  - Reset overrides everything. A job in progress is abandoned and no done pulse is issued.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: latch target = (num_passes==0 ? 1 : num_passes), set pass_cnt=0, go to ACCUM next cycle.
  - in_valid in IDLE is ignored.
- ACCUM:
  - in_ready=1 combinationally.
  - A beat is accepted when in_valid && in_ready.
  - On the first accepted beat (pass_cnt==0): acc[i] <= in_data[i]. No stale-value add; no clear cycle needed.
  - On later beats: acc[i] <= acc[i] + in_data[i], DW-bit wrap-around (overflow discarded).
  - pass_cnt increments per accepted beat. The beat with pass_cnt==target-1 moves the FSM to HOLD.
  - Cycles without in_valid hold state; there is no timeout.
- HOLD:
  - out_valid=1; out_data=acc, stable until handshake; in_ready=0.
  - out_valid && out_ready: done=1 for that cycle only (registered: asserted in the cycle after the handshake edge), go to IDLE.
- Latency: out_valid rises 1 cycle after the last accepted beat. Minimum job (1 pass, out_ready held 1) is start -> 1 cycle -> beat accepted -> out_valid next cycle -> IDLE next cycle.
- start outside IDLE is ignored; it is not queued.
- start coincident with the HOLD handshake is ignored; a new start must arrive in IDLE.
- out_data is driven from acc in every state (value undefined-but-stable outside HOLD). Consumers qualify with out_valid.
- busy = (state != IDLE).
- pass_cnt is PW bits wide; target up to 2^PW-1, with no wrap inside a job.

Optional Feature:
- Macro: PSUM_SAT_EN
- Defined:
  - Accumulation uses signed saturating add per lane: positive overflow clamps to 0x7FFF_FFFF, negative overflow to 0x8000_0000 (for DW=32).
  - A sticky per-job output port sat_flag (1 bit) is added. It is cleared on start and set if any lane saturated on any beat. It is valid with out_valid.
- Undefined: plain wrap-around add; the sat_flag port does not exist.

Test Plan:
- Single pass: start with num_passes=1; in_data[i]=i+1 -> out_valid 1 cycle after the beat; out_data[i]=i+1; done pulses once after handshake.
- Four passes with gaps: num_passes=4; beats in_data[i]=0x10 on every other cycle -> out_data[i]=0x40 for all lanes; in_ready=0 after the 4th beat.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 and out_data is unchanged; in_ready=0; extra in_valid is not accepted. Then out_ready=1 -> done=1 and return to IDLE.
- num_passes=0: treated as 1; single beat 0xDEADBEEF on lane 0 -> out_data[0]=0xDEADBEEF.
- Overflow, 2 passes of 0x7FFF_FFFF on lane 3:
  - Without PSUM_SAT_EN: out_data[3]=0xFFFF_FFFE.
  - With PSUM_SAT_EN: out_data[3]=0x7FFF_FFFF and sat_flag=1.
- Reset mid-job: rst=1 for 1 cycle after 2 of 4 beats -> all outputs 0 and state IDLE. A new 1-pass job with 0x5 gives 0x5 (no stale accumulation).
